// File: rtl/core_pkg.sv
// Shared RV32I core definitions: ALU control encodings, forwarding selects and
// the control bundle carried through the ID/EX register.
package core_pkg;

  localparam int ALUCTRL_WIDTH = 5;

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLL  = 5'd2;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT  = 5'd3;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLTU = 5'd4;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_XOR  = 5'd5;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRL  = 5'd6;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRA  = 5'd7;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR   = 5'd8;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND  = 5'd9;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_BEQ  = 5'd10;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_BNE  = 5'd11;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_BLT  = 5'd12;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_BGE  = 5'd13;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_BLTU = 5'd14;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_BGEU = 5'd15;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_LUI  = 5'd16;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_IMM  = 5'd17;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_MEM,
    FWD_WB
  } fwd_sel_e;

  typedef struct packed {
    logic                     mem_read;
    logic                     mem_write;
    logic                     reg_write;
    logic                     op1_pc;
    logic                     op2_imm;
    logic [ALUCTRL_WIDTH-1:0] alu_ctrl;
  } ex_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one source register; MEM beats WB, x0 never forwards.
module fwd_unit
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic              rs_use,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_reg_write,
  output fwd_sel_e          sel
);

  logic live;

  assign live = rs_use & (rs_addr != '0);

  always_comb begin
    sel = FWD_REG;
    if (live && mem_reg_write && (mem_rd_addr == rs_addr)) begin
      sel = FWD_MEM;
    end else if (live && wb_reg_write && (wb_rd_addr == rs_addr)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use bubble insertion, flush/hold handling and
// MEM/WB operand forwarding straight into the ALU operand muxes.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [REG_AW-1:0]    id_rs1_addr,
  input  logic [REG_AW-1:0]    id_rs2_addr,
  input  logic [REG_AW-1:0]    id_rd_addr,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [ALUCTRL_W-1:0] id_alu_ctrl,
  input  logic                 id_op1_pc,
  input  logic                 id_op2_imm,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 id_reg_write,
  input  logic [REG_AW-1:0]    mem_rd_addr,
  input  logic                 mem_reg_write,
  input  logic [XLEN-1:0]      mem_result,
  input  logic [REG_AW-1:0]    wb_rd_addr,
  input  logic                 wb_reg_write,
  input  logic [XLEN-1:0]      wb_result,
  output logic                 stall_id,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [REG_AW-1:0]    ex_rd_addr,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_reg_write,
  output logic [XLEN-1:0]      ex_alu_op1,
  output logic [XLEN-1:0]      ex_alu_op2,
  output logic [ALUCTRL_W-1:0] ex_alu_ctrl,
  output logic [XLEN-1:0]      ex_store_data
);

  localparam ex_ctrl_t CTRL_BUBBLE = '{
    mem_read:  1'b0,
    mem_write: 1'b0,
    reg_write: 1'b0,
    op1_pc:    1'b0,
    op2_imm:   1'b0,
    alu_ctrl:  ALU_ADD
  };

  logic              vld_p1;
  logic [XLEN-1:0]   pc_p1;
  logic [REG_AW-1:0] rs1_addr_p1;
  logic [REG_AW-1:0] rs2_addr_p1;
  logic [REG_AW-1:0] rd_addr_p1;
  logic [XLEN-1:0]   rs1_data_p1;
  logic [XLEN-1:0]   rs2_data_p1;
  logic [XLEN-1:0]   imm_p1;
  logic              use_rs1_p1;
  logic              use_rs2_p1;
  ex_ctrl_t          ctrl_p1;
  ex_ctrl_t          id_ctrl;
  logic              load_use;
  fwd_sel_e          fwd1_sel;
  fwd_sel_e          fwd2_sel;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  function automatic logic [XLEN-1:0] pick_operand(input fwd_sel_e sel,
                                                   input logic [XLEN-1:0] reg_val);
    case (sel)
      FWD_MEM: return mem_result;
      FWD_WB:  return wb_result;
      default: return reg_val;
    endcase
  endfunction

  always_comb begin
    id_ctrl           = CTRL_BUBBLE;
    id_ctrl.mem_read  = id_mem_read;
    id_ctrl.mem_write = id_mem_write;
    id_ctrl.reg_write = id_reg_write;
    id_ctrl.op1_pc    = id_op1_pc;
    id_ctrl.op2_imm   = id_op2_imm;
    id_ctrl.alu_ctrl  = id_alu_ctrl;
  end

  // A load in EX cannot forward its data yet; the consumer in ID must wait a cycle.
  assign load_use = vld_p1 & ctrl_p1.mem_read & (rd_addr_p1 != '0) &
                    ((id_use_rs1 & (id_rs1_addr == rd_addr_p1)) |
                     (id_use_rs2 & (id_rs2_addr == rd_addr_p1)));

  assign stall_id = id_valid & load_use & ~flush;

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= CTRL_BUBBLE;
      use_rs1_p1  <= 1'b0;
      use_rs2_p1  <= 1'b0;
      pc_p1       <= '0;
      rs1_addr_p1 <= '0;
      rs2_addr_p1 <= '0;
      rd_addr_p1  <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
    end else if (!hold) begin
      pc_p1       <= id_pc;
      rs1_addr_p1 <= id_rs1_addr;
      rs2_addr_p1 <= id_rs2_addr;
      rd_addr_p1  <= id_rd_addr;
      rs1_data_p1 <= id_rs1_data;
      rs2_data_p1 <= id_rs2_data;
      imm_p1      <= id_imm;
      if (flush || load_use) begin
        vld_p1     <= 1'b0;
        ctrl_p1    <= CTRL_BUBBLE;
        use_rs1_p1 <= 1'b0;
        use_rs2_p1 <= 1'b0;
      end else begin
        vld_p1     <= id_valid;
        ctrl_p1    <= id_ctrl;
        use_rs1_p1 <= id_use_rs1;
        use_rs2_p1 <= id_use_rs2;
      end
    end
  end

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr       (rs1_addr_p1),
    .rs_use        (use_rs1_p1),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd1_sel)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr       (rs2_addr_p1),
    .rs_use        (use_rs2_p1),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd2_sel)
  );

  assign fwd_rs1 = pick_operand(fwd1_sel, rs1_data_p1);
  assign fwd_rs2 = pick_operand(fwd2_sel, rs2_data_p1);

  assign ex_valid      = vld_p1;
  assign ex_pc         = pc_p1;
  assign ex_rd_addr    = rd_addr_p1;
  assign ex_mem_read   = vld_p1 & ctrl_p1.mem_read;
  assign ex_mem_write  = vld_p1 & ctrl_p1.mem_write;
  assign ex_reg_write  = vld_p1 & ctrl_p1.reg_write;
  assign ex_alu_ctrl   = ctrl_p1.alu_ctrl;
  assign ex_alu_op1    = ctrl_p1.op1_pc  ? pc_p1  : fwd_rs1;
  assign ex_alu_op2    = ctrl_p1.op2_imm ? imm_p1 : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded bench for id_ex_stage: directed hazard/forwarding scenarios plus
// randomized traffic against a behavioural model of the EX slot.
module tb_id_ex_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst, hold, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_ctrl;
  logic        id_use_rs1, id_use_rs2, id_op1_pc, id_op2_imm;
  logic        id_mem_read, id_mem_write, id_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        stall_id, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [31:0] ex_pc, ex_alu_op1, ex_alu_op2, ex_store_data;
  logic [4:0]  ex_rd_addr, ex_alu_ctrl;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REG_AW(5), .ALUCTRL_W(5)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_op1_pc(id_op1_pc), .id_op2_imm(id_op2_imm),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_alu_op1(ex_alu_op1), .ex_alu_op2(ex_alu_op2), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_store_data(ex_store_data)
  );

  // Instruction currently sitting in EX, as the reference sees it.
  typedef struct {
    bit          valid, mem_read, mem_write, reg_write, op1_pc, op2_imm, use1, use2, from_rst;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd, alu;
  } ex_model_t;

  typedef struct {
    logic        stall, valid, mr, mw, rw;
    logic [31:0] pc, op1, op2, store;
    logic [4:0]  rd, alu;
    bit          chk_data, chk_alu;
  } exp_t;

  ex_model_t m;
  exp_t      sb[$];
  int        checks = 0;
  int        failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_operand(input logic [4:0] a, input bit u,
                                              input logic [31:0] d);
    if (u && a != 0 && mem_reg_write && mem_rd_addr == a) return mem_result;
    if (u && a != 0 && wb_reg_write && wb_rd_addr == a) return wb_result;
    return d;
  endfunction

  function automatic bit ref_hazard();
    return m.valid && m.mem_read && m.rd != 0 &&
           ((id_use_rs1 && id_rs1_addr == m.rd) || (id_use_rs2 && id_rs2_addr == m.rd));
  endfunction

  task automatic push_expect();
    exp_t e;
    e.stall    = id_valid && ref_hazard() && !flush;
    e.valid    = m.valid;
    e.mr       = m.valid && m.mem_read;
    e.mw       = m.valid && m.mem_write;
    e.rw       = m.valid && m.reg_write;
    e.pc       = m.pc;
    e.rd       = m.rd;
    e.op1      = m.op1_pc  ? m.pc  : ref_operand(m.rs1, m.use1, m.rs1_data);
    e.op2      = m.op2_imm ? m.imm : ref_operand(m.rs2, m.use2, m.rs2_data);
    e.store    = ref_operand(m.rs2, m.use2, m.rs2_data);
    e.alu      = m.alu;
    e.chk_data = m.valid;
    e.chk_alu  = m.valid || m.from_rst;
    sb.push_back(e);
  endtask

  task automatic model_step();
    if (rst) begin
      m = '{default: 0};
      m.from_rst = 1;
    end else if (!hold) begin
      if (flush || ref_hazard()) begin
        m.valid = 0; m.mem_read = 0; m.mem_write = 0; m.reg_write = 0; m.from_rst = 0;
      end else begin
        m.valid = id_valid; m.pc = id_pc; m.rs1 = id_rs1_addr; m.rs2 = id_rs2_addr;
        m.rd = id_rd_addr; m.rs1_data = id_rs1_data; m.rs2_data = id_rs2_data;
        m.imm = id_imm; m.alu = id_alu_ctrl; m.op1_pc = id_op1_pc; m.op2_imm = id_op2_imm;
        m.mem_read = id_mem_read; m.mem_write = id_mem_write; m.reg_write = id_reg_write;
        m.use1 = id_use_rs1; m.use2 = id_use_rs2; m.from_rst = 0;
      end
    end
  endtask

  task automatic cycle();
    push_expect();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr();
    hold = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_ctrl = ALU_ADD;
    id_use_rs1 = 0; id_use_rs2 = 0; id_op1_pc = 0; id_op2_imm = 0;
    id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
    mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  task automatic set_lw_x5();
    clr();
    id_valid = 1; id_pc = 32'h200; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 5;
    id_rs1_addr = 1; id_use_rs1 = 1; id_rs1_data = 32'h300; id_op2_imm = 1; id_imm = 4;
  endtask

  task automatic set_add_x6_x5_x7();
    clr();
    id_valid = 1; id_pc = 32'h204; id_rs1_addr = 5; id_rs2_addr = 7; id_use_rs1 = 1;
    id_use_rs2 = 1; id_rd_addr = 6; id_reg_write = 1; id_rs1_data = 32'h1111; id_rs2_data = 3;
  endtask

  // Monitor: every cycle with an outstanding expectation is compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall_id", 32'(stall_id), 32'(e.stall));
        chk("ex_valid", 32'(ex_valid), 32'(e.valid));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
        if (e.chk_data) begin
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
          chk("ex_alu_op1", ex_alu_op1, e.op1);
          chk("ex_alu_op2", ex_alu_op2, e.op2);
          chk("ex_store_data", ex_store_data, e.store);
        end
        if (e.chk_alu) chk("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(e.alu));
      end
    end
  end

  initial begin
    // Reset while ID offers a writing instruction.
    clr(); rst = 1; id_valid = 1; id_reg_write = 1; id_pc = 32'h40; id_rd_addr = 9;
    @(posedge clk); model_step(); #1;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_ex_reg_write", 32'(ex_reg_write), 0);
    chk("rst_ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(ALU_ADD));
    cycle();
    rst = 0; #1;
    cycle();
    chk("rst_release_capture", 32'(ex_valid), 1);
    chk("rst_release_pc", ex_pc, 32'h40);

    // MEM beats WB; WB used once MEM stops writing; x0 never forwarded.
    clr(); id_valid = 1; id_pc = 32'h100; id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 3;
    id_use_rs1 = 1; id_use_rs2 = 1; id_rs1_data = 5; id_rs2_data = 7; id_reg_write = 1;
    cycle();
    clr(); hold = 1; mem_rd_addr = 1; mem_reg_write = 1; mem_result = 32'h10;
    wb_rd_addr = 1; wb_reg_write = 1; wb_result = 32'h20; #1;
    chk("fwd_mem_priority", ex_alu_op1, 32'h10);
    cycle();
    mem_reg_write = 0; #1;
    chk("fwd_wb", ex_alu_op1, 32'h20);
    cycle();
    clr(); id_valid = 1; id_pc = 32'h104; id_use_rs1 = 1; id_rs1_addr = 0; id_rd_addr = 4;
    cycle();
    clr(); hold = 1; mem_rd_addr = 0; mem_reg_write = 1; mem_result = 32'hDEAD;
    wb_rd_addr = 0; wb_reg_write = 1; wb_result = 32'hBEEF; #1;
    chk("fwd_x0", ex_alu_op1, 0);
    cycle();

    // Load-use: exactly one bubble, then the consumer picks up the load from WB.
    set_lw_x5(); cycle();
    set_add_x6_x5_x7(); #1;
    chk("load_use_stall", 32'(stall_id), 1);
    cycle();
    chk("bubble_valid", 32'(ex_valid), 0);
    chk("bubble_mem_read", 32'(ex_mem_read), 0);
    chk("bubble_reg_write", 32'(ex_reg_write), 0);
    wb_rd_addr = 5; wb_reg_write = 1; wb_result = 32'hABCD; #1;
    chk("after_bubble_stall", 32'(stall_id), 0);
    cycle();
    chk("consumer_valid", 32'(ex_valid), 1);
    chk("consumer_op1_wb", ex_alu_op1, 32'hABCD);
    cycle();

    // No stall when the ID instruction reads nothing.
    set_lw_x5(); cycle();
    clr(); id_valid = 1; id_pc = 32'h208; id_rd_addr = 5; id_rs1_addr = 5; id_reg_write = 1;
    id_op2_imm = 1; id_imm = 32'h12345000; id_alu_ctrl = ALU_IMM; #1;
    chk("lui_no_stall", 32'(stall_id), 0);
    cycle();
    chk("lui_captured", 32'(ex_valid), 1);
    chk("lui_op2", ex_alu_op2, 32'h12345000);

    // Hold beats flush; flush alone leaves a bubble; flush masks stall_id.
    clr(); id_valid = 1; id_pc = 32'h300; id_mem_write = 1; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rs1_addr = 1; id_rs2_addr = 2; id_op2_imm = 1; id_imm = 8;
    cycle();
    clr(); id_valid = 1; id_reg_write = 1; hold = 1; flush = 1;
    cycle();
    chk("hold_over_flush", 32'(ex_valid), 1);
    chk("hold_keeps_store", 32'(ex_mem_write), 1);
    hold = 0; #1;
    cycle();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_mem_write", 32'(ex_mem_write), 0);
    set_lw_x5(); cycle();
    set_add_x6_x5_x7(); flush = 1; #1;
    chk("flush_masks_stall", 32'(stall_id), 0);
    cycle();

    // Store data is forwarded even when op2 is the immediate.
    clr(); id_valid = 1; id_pc = 32'h400; id_rs1_addr = 1; id_rs2_addr = 2; id_use_rs1 = 1;
    id_use_rs2 = 1; id_rs1_data = 32'h1000; id_rs2_data = 32'h77; id_op2_imm = 1; id_imm = 8;
    id_mem_write = 1;
    cycle();
    clr(); hold = 1; mem_rd_addr = 2; mem_reg_write = 1; mem_result = 32'h55; #1;
    chk("sw_op2_imm", ex_alu_op2, 8);
    chk("sw_store_fwd", ex_store_data, 32'h55);
    cycle();

    // Reset in the middle of a stall discards the hazard.
    set_lw_x5(); cycle();
    set_add_x6_x5_x7(); #1;
    chk("pre_rst_stall", 32'(stall_id), 1);
    rst = 1; cycle();
    rst = 0; #1;
    chk("post_rst_stall", 32'(stall_id), 0);
    cycle();
    chk("post_rst_capture", 32'(ex_valid), 1);

    // Randomized traffic with a small register window to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      rst           = ($urandom_range(0, 49) == 0);
      hold          = ($urandom_range(0, 7) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      id_valid      = ($urandom_range(0, 99) < 85);
      id_pc         = $urandom;
      id_rs1_addr   = 5'($urandom_range(0, 7));
      id_rs2_addr   = 5'($urandom_range(0, 7));
      id_rd_addr    = 5'($urandom_range(0, 7));
      id_rs1_data   = (id_rs1_addr == 0) ? 32'h0 : $urandom;
      id_rs2_data   = (id_rs2_addr == 0) ? 32'h0 : $urandom;
      id_imm        = $urandom;
      id_alu_ctrl   = 5'($urandom_range(0, 17));
      id_use_rs1    = 1'($urandom_range(0, 1));
      id_use_rs2    = 1'($urandom_range(0, 1));
      id_op1_pc     = ($urandom_range(0, 3) == 0);
      id_op2_imm    = 1'($urandom_range(0, 1));
      id_mem_read   = ($urandom_range(0, 2) == 0);
      id_mem_write  = ($urandom_range(0, 4) == 0);
      id_reg_write  = 1'($urandom_range(0, 1));
      mem_rd_addr   = 5'($urandom_range(0, 7));
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_result    = $urandom;
      wb_rd_addr    = 5'($urandom_range(0, 7));
      wb_reg_write  = 1'($urandom_range(0, 1));
      wb_result     = $urandom;
      cycle();
    end

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core. It feeds the ALU directly.
- Captures decoded operands and control from ID.
- Detects load-use hazards, inserts bubbles, and honours branch flush and global hold.
- Resolves rs1/rs2 forwarding from MEM/WB and drives the final ALU operands (op1, op2, ALUCtrl) plus store data.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-address width.
- ALUCTRL_W, 5, ALU control width; encodings come from the shared package (ADD=0 … IMM=17).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- hold  in  1  global pipeline freeze (memory wait); EX register keeps its value.
- flush  in  1  branch/jump redirect from EX; the next EX content is a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_AW each  register indices.
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2.
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data (write-first regfile).
- id_imm  in  XLEN  sign-extended immediate.
- id_alu_ctrl  in  ALUCTRL_W  ALU operation.
- id_op1_pc  in  1  op1 = PC (AUIPC/JAL).
- id_op2_imm  in  1  op2 = immediate.
- id_mem_read, id_mem_write, id_reg_write  in  1 each  control passthrough.
- mem_rd_addr  in  REG_AW  destination in MEM.
- mem_reg_write  in  1  MEM writes rd.
- mem_result  in  XLEN  ALU result in MEM.
- wb_rd_addr  in  REG_AW  destination in WB.
- wb_reg_write  in  1  WB writes rd.
- wb_result  in  XLEN  final writeback value (includes load data).
- stall_id  out  1  freeze IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc  out  XLEN  registered PC.
- ex_rd_addr  out  REG_AW  registered rd.
- ex_mem_read, ex_mem_write, ex_reg_write  out  1 each  registered control, gated by ex_valid.
- ex_alu_op1, ex_alu_op2  out  XLEN each  ALU rs1/rs2 inputs.
- ex_alu_ctrl  out  ALUCTRL_W  ALU control.
- ex_store_data  out  XLEN  forwarded rs2 for stores.

Behaviour:
- Registers (all synchronous to clk):
  - pc, rs1/rs2 addr+data, rd, imm, alu_ctrl, op1_pc, op2_imm, mem_read, mem_write, reg_write, use_rs1/2, valid.
- Reset (rst=1 at posedge):
  - valid=0; all control bits 0; data fields 0; alu_ctrl=ADD.
  - Hence ex_valid=0, ex_mem_*=0, ex_reg_write=0.
- load_use (combinational) is true when all of the following hold:
  - ex_valid & ex_mem_read & ex_rd_addr≠0;
  - (id_use_rs1 & id_rs1_addr==ex_rd_addr) | (id_use_rs2 & id_rs2_addr==ex_rd_addr).
- stall_id = id_valid & load_use & ~flush.
- Per-cycle update priority:
  1. rst
  2. hold (all registers keep their value; flush/load_use are not applied, and the source keeps asserting)
  3. flush (valid←0, control bits←0)
  4. load_use (bubble: valid←0, control←0)
  5. normal capture (valid←id_valid; fields←id_*)
- Bubbles never assert mem_read, mem_write or reg_write downstream.
- Forwarding (combinational on registered fields), evaluated separately for rs1 and rs2:
  - If use_rsN & rsN_addr≠0 & mem_reg_write & mem_rd_addr==rsN_addr → mem_result.
  - Else if use_rsN & rsN_addr≠0 & wb_reg_write & wb_rd_addr==rsN_addr → wb_result.
  - Else → registered rsN_data.
  - MEM has priority over WB; x0 is never forwarded and always reads 0.
- A load sitting in MEM is never forwarded from MEM; the load-use bubble guarantees it has reached WB first.
- Operand selection:
  - ex_alu_op1 = op1_pc ? ex_pc : fwd_rs1.
  - ex_alu_op2 = op2_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 (always forwarded, regardless of op2_imm).
- Latency: one cycle ID→EX; forwarding adds zero cycles; a load-use hazard costs exactly one bubble.
- Reset mid-stall: the bubble is discarded; stall_id drops in the cycle after rst deasserts unless the hazard reappears.

Decomposition:
- Package core_pkg:
  - ALU control localparams (ADD…IMM, 5-bit).
  - fwd_sel_e enum {FWD_REG, FWD_MEM, FWD_WB}.
  - ex_ctrl_t packed struct {mem_read, mem_write, reg_write, op1_pc, op2_imm, alu_ctrl}.
- Sub-module fwd_unit:
  - Combinational; inputs rs_addr, use, mem/wb rd+reg_write.
  - Outputs fwd_sel_e; instantiated twice (rs1, rs2).

Test Plan:
1. Reset: rst=1 with id_valid=1, id_reg_write=1 → after posedge ex_valid=0, ex_reg_write=0, ex_alu_ctrl=ADD. Release rst → next posedge captures the ID instruction.
2. MEM/WB priority: EX holds add x3,x1,x2 (rs1_data=5); mem_rd=1 with mem_result=0x10; wb_rd=1 with wb_result=0x20 → ex_alu_op1=0x10. Drop mem_reg_write → ex_alu_op1=0x20. Set rs1=x0 with mem_rd=0 → ex_alu_op1=0.
3. Load-use: EX holds lw x5 (mem_read=1); ID holds add x6,x5,x7 → stall_id=1, next EX ex_valid=0 with all control 0. Cycle after: the add is captured, stall_id=0. With wb_rd=5 and wb_result=0xABCD, ex_alu_op1=0xABCD.
4. No false stall: EX lw x5; ID lui x5 (use_rs1=use_rs2=0) → stall_id=0, lui captured.
5. Flush vs hold: flush=1 & hold=1 → EX unchanged, ex_valid stays 1. Next cycle hold=0, flush=1 → ex_valid=0, ex_mem_write=0. flush=1 during load_use → stall_id=0.
6. Store data: sw x2,8(x1), op2_imm=1, imm=8, mem_rd=2 with mem_result=0x55 → ex_alu_op2=8, ex_store_data=0x55.
